kb_cmd_scheduler: RTL and testbench

Frame-synchronous keyboard command scheduler between the debounced keyboard path and the game/VGA controller. Captures each strobed PS/2 scan code, maps it to a 3-bit game command and queues it in a small FIFO. Releases at most one command per vertical-blanking interval over a valid/ready handshake, so game state only changes between frames. Runs in the 25 MHz pixel-clock domain.

---
 rtl/eksbox_pkg.sv | 41 ++++
 rtl/kb_cmd_fifo.sv | 46 ++++
 rtl/kb_cmd_scheduler.sv | 104 ++++++++++
 tb/tb_kb_cmd_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eksbox_pkg.sv
// Shared command codes, scan-code constants and scheduler state encoding
// for the keyboard-to-game command path.
package eksbox_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_FIRE  = 3'd5,
    CMD_START = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_SPENT   = 2'd2
  } sched_state_e;

  localparam logic [7:0] SC_UP      = 8'h1D;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_FIRE    = 8'h29;
  localparam logic [7:0] SC_START   = 8'h5A;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  function automatic cmd_e map_scan(input logic [7:0] code);
    case (code)
      SC_UP:    return CMD_UP;
      SC_DOWN:  return CMD_DOWN;
      SC_LEFT:  return CMD_LEFT;
      SC_RIGHT: return CMD_RIGHT;
      SC_FIRE:  return CMD_FIRE;
      SC_START: return CMD_START;
      default:  return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kb_cmd_fifo.sv
// Small command FIFO, DEPTH x 3 bits. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module kb_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [2:0] i_din,
  output logic [2:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/kb_cmd_scheduler.sv
// Frame-synchronous keyboard command scheduler: one queued command offered per
// vertical blanking interval. Define KBQ_BREAK_FILTER_EN to drop key releases.
module kb_cmd_scheduler
  import eksbox_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int VRES  = 480
) (
  input  logic         CLK,
  input  logic         ARST_L,
  input  logic         KBSTROBE,
  input  logic [7:0]   KBCODE,
  input  logic [9:0]   VCOORD,
  output logic [2:0]   CMD,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic         QFULL,
  output logic         OVERFLOW,
  output sched_state_e o_dbg_state
);

  // Handshake: CMD is offered while CMD_VALID is high and is held unchanged
  // until the consumer raises CMD_READY; transfer happens on the clock edge
  // where both are high, and CMD_VALID is low on the following cycle.

  sched_state_e r_state;
  sched_state_e w_next;
  logic         r_kbstrobe_d;
  logic         r_valid;
  logic [2:0]   r_cmd;
  logic         r_ovf;
  logic         w_edge;
  logic         w_vblank;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [2:0]   w_dout;
  cmd_e         w_code_cmd;

  assign w_edge     = KBSTROBE && !r_kbstrobe_d;
  assign w_vblank   = (VCOORD >= 10'(VRES));
  assign w_code_cmd = map_scan(KBCODE);
  assign w_pop      = (r_state == ST_PRESENT) && CMD_READY;

`ifdef KBQ_BREAK_FILTER_EN
  logic r_break;

  // The code strobed after a break prefix is the released key; swallow it.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) r_break <= 1'b0;
    else if (w_edge) r_break <= r_break ? 1'b0 : (KBCODE == BREAK_CODE);
  end

  assign w_push = w_edge && !r_break && (w_code_cmd != CMD_NONE);
`else
  assign w_push = w_edge && (w_code_cmd != CMD_NONE);
`endif

  kb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (ARST_L),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_code_cmd),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_vblank && !w_empty) w_next = ST_PRESENT;
      ST_PRESENT: if (CMD_READY) w_next = ST_SPENT;
      ST_SPENT:   if (!w_vblank) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // The head cannot move while PRESENT (only PRESENT pops), so CMD stays put.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_state      <= ST_IDLE;
      r_kbstrobe_d <= 1'b0;
      r_valid      <= 1'b0;
      r_cmd        <= 3'd0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_kbstrobe_d <= KBSTROBE;
      r_valid      <= (w_next == ST_PRESENT);
      r_cmd        <= (w_next == ST_PRESENT) ? w_dout : 3'd0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign CMD         = r_cmd;
  assign CMD_VALID   = r_valid;
  assign QFULL       = w_full;
  assign OVERFLOW    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_kb_cmd_scheduler.sv
// Bench for kb_cmd_scheduler: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based reference.
module tb_kb_cmd_scheduler;
  import eksbox_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         strobe;
  logic [7:0]   code;
  logic [9:0]   vc;
  logic         ready;
  logic [2:0]   cmd;
  logic         valid;
  logic         qfull;
  logic         ovf;
  sched_state_e dbg;

  int checks = 0;
  int errors = 0;

  // Reference: command queue, "offering" and "served this blank" flags.
  int  m_q[$];
  bit  m_prev, m_offer, m_done, m_ovf, m_brk;
  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  typedef struct {
    bit         s;
    logic [7:0] c;
    logic [9:0] v;
    bit         r;
    bit         ev;
    logic [2:0] ecmd;
    bit         efull;
    bit         eovf;
  } vec_t;

  vec_t vecs[16];

  kb_cmd_scheduler #(.DEPTH(DEPTH), .VRES(480)) dut (
    .CLK         (clk),
    .ARST_L      (rst_n),
    .KBSTROBE    (strobe),
    .KBCODE      (code),
    .VCOORD      (vc),
    .CMD         (cmd),
    .CMD_VALID   (valid),
    .CMD_READY   (ready),
    .QFULL       (qfull),
    .OVERFLOW    (ovf),
    .o_dbg_state (dbg)
  );

  always #20 clk = ~clk;

  function automatic int ref_map(input logic [7:0] c);
    case (c)
      8'h1D:   return 1;
      8'h1B:   return 2;
      8'h1C:   return 3;
      8'h23:   return 4;
      8'h29:   return 5;
      8'h5A:   return 6;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = 0; m_offer = 0; m_done = 0; m_ovf = 0; m_brk = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] c, input logic [9:0] v, input bit r);
    bit vb;
    int mc;
    vb = (v >= 10'd480);
    if (m_offer) begin
      if (r) begin
        void'(m_q.pop_front());
        m_offer = 0;
        m_done  = 1;
      end
    end else if (m_done) begin
      if (!vb) m_done = 0;
    end else if (vb && m_q.size() > 0) begin
      m_offer = 1;
    end
    if (s && !m_prev) begin
      mc = ref_map(c);
`ifdef KBQ_BREAK_FILTER_EN
      if (m_brk) begin
        m_brk = 0;
        mc = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end
`endif
      if (mc != 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(mc);
        else m_ovf = 1;
      end
    end
    m_prev = s;
  endtask

  task automatic check_model();
    check("model_valid", valid, m_offer);
    check("model_cmd", cmd, m_offer ? m_q[0] : 0);
    check("model_qfull", qfull, m_q.size() == DEPTH);
    check("model_overflow", ovf, m_ovf);
  endtask

  // One clock: drive at negedge, step model at posedge, compare at negedge.
  task automatic cyc(input bit s, input logic [7:0] c, input logic [9:0] v, input bit r);
    strobe = s; code = c; vc = v; ready = r;
    #1;
    if (valid && r) got_q.push_back(cmd);
    @(posedge clk);
    model_step(s, c, v, r);
    @(negedge clk);
    check_model();
  endtask

  task automatic press(input logic [7:0] c, input logic [9:0] v);
    cyc(1'b1, c, v, 1'b0);
    cyc(1'b0, c, v, 1'b0);
  endtask

  task automatic frame(input int nblank, input bit r);
    for (int i = 0; i < nblank; i++) cyc(1'b0, 8'h00, 10'(480 + i), r);
    cyc(1'b0, 8'h00, 10'd100, r);
    cyc(1'b0, 8'h00, 10'd101, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    strobe = 1'b0; code = 8'h00; vc = 10'd0; ready = 1'b0;
    model_reset();
    got_q.delete();
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_qfull", qfull, 0);
    check("rst_overflow", ovf, 0);
    check("rst_state", int'(dbg), int'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_delivered(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_item%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    bit         rs;
    logic [7:0] rc;
    logic [7:0] codes[10];
    int         f;
    logic [9:0] rv;

    vecs[0]  = '{1'b1, 8'h1D, 10'd100, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 10'd100, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 10'd480, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 10'd480, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 10'd481, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 10'd10,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h1D, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h1B, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h1C, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 10'd10,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h23, 10'd10,  1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 10'd10,  1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 8'h29, 10'd10,  1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 10'd10,  1'b0, 1'b0, 3'd0, 1'b1, 1'b1};

    codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'hF0, 8'h00, 8'h12, 8'hF0};

    // Directed table: single delivery, then fill past DEPTH.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].r);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].ev);
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].ecmd);
      check($sformatf("vec%0d_qfull", i), qfull, vecs[i].efull);
      check($sformatf("vec%0d_overflow", i), ovf, vecs[i].eovf);
    end
    got_q.delete();
    repeat (6) frame(3, 1'b1);
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
    check_delivered("overflow_delivery");
    check("overflow_sticky", ovf, 1);

    // Push on the pop cycle of a full FIFO: both happen, no overflow.
    do_reset();
    press(8'h1D, 10'd100);
    press(8'h1B, 10'd100);
    press(8'h1C, 10'd100);
    press(8'h23, 10'd100);
    check("pre_pop_full", qfull, 1);
    cyc(1'b0, 8'h00, 10'd480, 1'b0);
    cyc(1'b0, 8'h00, 10'd481, 1'b0);
    cyc(1'b1, 8'h29, 10'd482, 1'b1);
    check("poppush_overflow", ovf, 0);
    check("poppush_qfull", qfull, 1);
    cyc(1'b0, 8'h00, 10'd483, 1'b1);
    cyc(1'b0, 8'h00, 10'd100, 1'b0);
    repeat (6) frame(3, 1'b1);
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    check_delivered("poppush_delivery");

    // READY held low past the end of vblank.
    do_reset();
    press(8'h5A, 10'd100);
    cyc(1'b0, 8'h00, 10'd480, 1'b0);
    cyc(1'b0, 8'h00, 10'd490, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 10'd50, 1'b0);
      check("hold_valid", valid, 1);
      check("hold_cmd", cmd, 6);
    end
    cyc(1'b0, 8'h00, 10'd50, 1'b1);
    check("hold_done_valid", valid, 0);
    check("hold_spent_state", int'(dbg), int'(ST_SPENT));
    cyc(1'b0, 8'h00, 10'd51, 1'b0);
    check("hold_idle_state", int'(dbg), int'(ST_IDLE));

    // Reset while a command is offered: VALID drops without a clock edge.
    do_reset();
    press(8'h1D, 10'd100);
    press(8'h1B, 10'd100);
    cyc(1'b0, 8'h00, 10'd480, 1'b0);
    check("midrst_pre_valid", valid, 1);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_async_valid", valid, 0);
    check("midrst_async_cmd", cmd, 0);
    @(negedge clk);
    do_reset();
    repeat (3) frame(3, 1'b1);
    check("midrst_queue_lost", got_q.size(), 0);

    // Key press + release.
    do_reset();
    press(8'h1C, 10'd100);
    press(8'hF0, 10'd100);
    press(8'h1C, 10'd100);
    repeat (4) frame(3, 1'b1);
`ifdef KBQ_BREAK_FILTER_EN
    exp_q = '{3'd3};
`else
    exp_q = '{3'd3, 3'd3};
`endif
    check_delivered("break");

    // Random traffic over a compressed frame with a vblank at lines >= 480.
    do_reset();
    rs = 0;
    rc = 8'h00;
    f = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rs) begin
        if ($urandom_range(0, 1) == 0) rs = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        rs = 1;
        rc = codes[$urandom_range(0, 9)];
      end
      if (f < 19) rv = 10'(f * 25);
      else if (f == 19) rv = 10'd479;
      else rv = 10'(480 + (f - 20) * 4);
      cyc(rs, rc, rv, $urandom_range(0, 9) < 7);
      f = (f == 27) ? 0 : f + 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
